fp16_mul_arbiter: RTL
=====================

Name: fp16_mul_arbiter

Overview:
- Round-robin arbiter and sequencer that shares one FP16 (1-5-10, bias 15) logarithmic multiplier datapath among N_REQ requesters.
- Accepts operand pairs over per-requester valid/ready handshakes and issues one multiply at a time with a start pulse.
- Captures the result after a fixed datapath latency and returns it, tagged with the requester ID, over a response handshake.
- Sits between the operand-collection front ends and the single shared multiplier core.

Parameters:
N_REQ, 4, number of requesters (2..8)
ID_W, 2, width of requester ID; must satisfy 2**ID_W >= N_REQ
MUL_LAT, 2, cycles from the mul_start cycle to the edge at which mul_result is valid (1..15)

Ports:
clk  input  1  clock, rising edge
rst  input  1  asynchronous reset, active-high
req_valid  input  N_REQ  per-requester operand pair valid
req_a  input  16*N_REQ  operand A of requester i at [16*i +: 16]
req_b  input  16*N_REQ  operand B of requester i at [16*i +: 16]
req_ready  output  N_REQ  one-hot accept pulse
mul_start  output  1  one-cycle issue pulse to the shared multiplier
mul_a  output  16  operand A to the multiplier
mul_b  output  16  operand B to the multiplier
mul_result  input  16  multiplier result {sign, exp[4:0], mant[9:0]}
rsp_valid  output  1  response valid
rsp_id  output  ID_W  requester index of the response
rsp_data  output  16  captured product
rsp_ready  input  1  response consumer accept
busy  output  1  high in any state other than IDLE

Behaviour:
- Clocking: single clock domain on clk. rst is asynchronous and active-high.
- Reset values: state=IDLE, rr_ptr=0, wait counter=0, every output 0, mul_a=mul_b=0, rsp_data=0.
- Reset asserted mid-operation aborts the in-flight job with no response. A late mul_result is ignored.
- State IDLE:
  - If any req_valid is high, pick the winner w: the first requester with req_valid=1, searching rr_ptr, rr_ptr+1, ... mod N_REQ.
  - Assert req_ready[w]=1 combinationally in this same cycle. A transfer happens when req_valid[w] && req_ready[w].
  - At the edge, latch req_a[w], req_b[w] into op registers, latch w into id_reg, go to ISSUE.
  - If no request is valid, stay in IDLE.
- req_ready is high only in IDLE, for exactly one bit, and only when that bit's req_valid is high.
- Requesters must hold valid and operands stable until accepted. A non-winning valid request stays pending.
- State ISSUE (1 cycle):
  - mul_start=1. mul_a/mul_b come from the op registers.
  - Load wait counter with MUL_LAT-1, go to WAIT.
- State WAIT:
  - mul_a/mul_b stay stable; mul_start=0.
  - Decrement the counter each cycle. On the cycle the counter is 0, capture mul_result into rsp_data at the edge and go to RESP.
  - Net effect: capture happens at the MUL_LAT-th rising edge after the ISSUE edge.
  - MUL_LAT=1 means WAIT lasts one cycle.
- State RESP:
  - rsp_valid=1, with rsp_id=id_reg and rsp_data stable.
  - When rsp_ready=1, the handshake completes: rr_ptr <= (id_reg+1) mod N_REQ, go to IDLE.
  - While rsp_ready=0, hold indefinitely.
- Back-to-back jobs: minimum of one IDLE cycle between jobs, so throughput is one product per MUL_LAT+3 cycles.
- Fairness: a continuously asserted request is granted within N_REQ jobs.
- rr_ptr changes only on response completion, never on grant.
- Arithmetic: none is performed here; operand and result bits pass through unmodified. rr_ptr wraps modulo N_REQ, including non-power-of-two N_REQ.
- Simultaneous events:
  - A req_valid rising in the same cycle the FSM returns to IDLE is seen in the next IDLE cycle.
  - A request deasserted before acceptance is a protocol violation, outside the spec.
- busy = (state != IDLE).

Test Plan:
Bench stub multiplier: returns mul_a ^ mul_b registered through MUL_LAT stages; MUL_LAT=2, N_REQ=4 unless noted.
- Single request: req_valid=0001, a=0x3E00, b=0x4000 -> req_ready=0001 for 1 cycle, mul_start one cycle later, rsp_valid with rsp_id=0, rsp_data=0x7E00, 4 cycles after accept; busy high from accept+1 until the rsp handshake.
- All four requesters valid continuously -> grants in order 0,1,2,3,0; each rsp_id matches, rsp_data = a_i ^ b_i.
- Round-robin skip: rr_ptr=2, req_valid=1001 -> requester 3 granted first, then 0; requester 1, never valid, never gets req_ready.
- Backpressure: rsp_ready held 0 for 10 cycles in RESP -> rsp_valid, rsp_id and rsp_data stable, no req_ready and no mul_start; the job completes on the rsp_ready pulse.
- Reset mid-WAIT: assert rst in the first WAIT cycle -> all outputs 0 immediately; after release, rr_ptr=0 and no stale response appears.
- MUL_LAT=1 and MUL_LAT=15 with N_REQ=3 -> capture at exactly MUL_LAT edges after ISSUE; rr_ptr wraps 2->0.

Source files
------------

// File: rtl/fp16_mul_arbiter.sv
// Round-robin front end for one shared FP16 multiplier: grants one requester at a time,
// issues its operands with a start pulse, captures the product after MUL_LAT cycles, and returns it tagged.
module fp16_mul_arbiter #(
  parameter int N_REQ   = 4,
  parameter int ID_W    = 2,
  parameter int MUL_LAT = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [N_REQ-1:0]     req_valid,
  input  logic [16*N_REQ-1:0]  req_a,
  input  logic [16*N_REQ-1:0]  req_b,
  output logic [N_REQ-1:0]     req_ready,
  output logic                 mul_start,
  output logic [15:0]          mul_a,
  output logic [15:0]          mul_b,
  input  logic [15:0]          mul_result,
  output logic                 rsp_valid,
  output logic [ID_W-1:0]      rsp_id,
  output logic [15:0]          rsp_data,
  input  logic                 rsp_ready,
  output logic                 busy
);

  // Handshakes: a transfer happens on a rising edge where valid && ready are both high.
  // req_ready is a combinational one-hot grant in IDLE; rsp_valid holds until rsp_ready.
  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESP} state_t;

  state_t          r_state;
  state_t          w_next_state;
  logic [ID_W-1:0] r_rr_ptr;
  logic [ID_W-1:0] r_id;
  logic [ID_W-1:0] w_winner;
  logic [ID_W-1:0] w_next_ptr;
  logic            w_any;
  int              w_idx;
  logic [3:0]      r_cnt;
  logic [15:0]     r_op_a;
  logic [15:0]     r_op_b;
  logic [15:0]     r_rsp_data;
  logic            w_accept;
  logic            w_capture;
  logic            w_rsp_done;

  // Scan offsets from farthest to nearest so the nearest valid requester to rr_ptr wins.
  always_comb begin
    w_any    = 1'b0;
    w_winner = '0;
    w_idx    = 0;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      w_idx = int'(r_rr_ptr) + k;
      if (w_idx >= N_REQ) w_idx = w_idx - N_REQ;
      if (req_valid[w_idx]) begin
        w_any    = 1'b1;
        w_winner = ID_W'(w_idx);
      end
    end
  end

  assign w_next_ptr = (r_id == ID_W'(N_REQ - 1)) ? '0 : r_id + 1'b1;

  always_comb begin
    w_next_state = r_state;
    w_accept     = 1'b0;
    w_capture    = 1'b0;
    w_rsp_done   = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_any) begin
          w_accept     = 1'b1;
          w_next_state = S_ISSUE;
        end
      end
      S_ISSUE: w_next_state = S_WAIT;
      S_WAIT: begin
        if (r_cnt == 4'd0) begin
          w_capture    = 1'b1;
          w_next_state = S_RESP;
        end
      end
      S_RESP: begin
        if (rsp_ready) begin
          w_rsp_done   = 1'b1;
          w_next_state = S_IDLE;
        end
      end
      default: w_next_state = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rr_ptr   <= '0;
      r_id       <= '0;
      r_cnt      <= 4'd0;
      r_op_a     <= 16'd0;
      r_op_b     <= 16'd0;
      r_rsp_data <= 16'd0;
    end else begin
      if (w_accept) begin
        r_op_a <= req_a[16*w_winner +: 16];
        r_op_b <= req_b[16*w_winner +: 16];
        r_id   <= w_winner;
      end
      // Counter reaches zero in the last WAIT cycle, MUL_LAT edges after the start pulse.
      if (r_state == S_ISSUE) begin
        r_cnt <= 4'(MUL_LAT - 1);
      end else if (r_state == S_WAIT && r_cnt != 4'd0) begin
        r_cnt <= r_cnt - 1'b1;
      end
      if (w_capture) r_rsp_data <= mul_result;
      if (w_rsp_done) r_rr_ptr <= w_next_ptr;
    end
  end

  assign req_ready = (r_state == S_IDLE && w_any) ? (N_REQ'(1) << w_winner) : '0;
  assign mul_start = (r_state == S_ISSUE);
  assign mul_a     = r_op_a;
  assign mul_b     = r_op_b;
  assign rsp_valid = (r_state == S_RESP);
  assign rsp_id    = r_id;
  assign rsp_data  = r_rsp_data;
  assign busy      = (r_state != S_IDLE);

endmodule
